// File: rtl/ic_pkg.sv
// Shared definitions for the 2x2 interconnect: command codes, arbiter states, bus payload.
package ic_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Read data returned to a master whose transaction timed out.
  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Request payload forwarded from the granted master to the slave.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              cmd;
  } req_payload_t;

endpackage

// File: rtl/slave_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie, the master that did not win last time wins.
module rr_pick2 (
  input  logic [1:0] elig,
  input  logic       last,
  output logic [1:0] pick
);

  // Single requester passes straight through; a tie goes to the other master.
  always_comb begin
    pick = elig;
    if (&elig) begin
      pick = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/slave_port_arbiter.sv
// Shares one slave port between two masters: address decode, round-robin grant,
// grant held until slave ack or timeout.
module slave_port_arbiter
  import ic_pkg::*;
#(
  parameter int unsigned       SLAVE_ID = 0,
  parameter int unsigned       ADDR_BIT = 31,
  parameter int unsigned       TIMEOUT  = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              master_0_req,
  input  logic [ADDR_W-1:0] master_0_addr,
  input  logic [DATA_W-1:0] master_0_wdata,
  input  logic              master_0_cmd,
  output logic [DATA_W-1:0] master_0_rdata,
  output logic              master_0_ack,
  input  logic              master_1_req,
  input  logic [ADDR_W-1:0] master_1_addr,
  input  logic [DATA_W-1:0] master_1_wdata,
  input  logic              master_1_cmd,
  output logic [DATA_W-1:0] master_1_rdata,
  output logic              master_1_ack,
  output logic              slave_req,
  output logic [ADDR_W-1:0] slave_addr,
  output logic [DATA_W-1:0] slave_wdata,
  output logic              slave_cmd,
  input  logic [DATA_W-1:0] slave_rdata,
  input  logic              slave_ack,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  timeout_cnt
);

  arb_state_t       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;

  logic [1:0]        elig;
  logic [1:0]        pick;
  logic              busy;
  logic              timeout_hit;
  logic              done;
  logic [DATA_W-1:0] rsp_data;
  req_payload_t      pl_0, pl_1, sel_pl;

  // Decode: a master is eligible when it requests and its address selects this slave.
  assign elig[0] = master_0_req && (master_0_addr[ADDR_BIT] == 1'(SLAVE_ID));
  assign elig[1] = master_1_req && (master_1_addr[ADDR_BIT] == 1'(SLAVE_ID));

  rr_pick2 u_pick (
    .elig (elig),
    .last (last_grant_q),
    .pick (pick)
  );

  assign busy        = (state_q == BUSY);
  assign timeout_hit = busy && (wait_cnt_q == CNT_W'(TIMEOUT - 1));
  assign done        = busy && (slave_ack || timeout_hit);
  // A slave ack on the timeout cycle wins over the error completion.
  assign rsp_data    = slave_ack ? slave_rdata : ERR_DATA;

  assign pl_0   = '{addr: master_0_addr, wdata: master_0_wdata, cmd: master_0_cmd};
  assign pl_1   = '{addr: master_1_addr, wdata: master_1_wdata, cmd: master_1_cmd};
  assign sel_pl = grant_q[1] ? pl_1 : pl_0;

  // State, grant and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_grant_q  <= 1'b1;
      wait_cnt_q    <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold grant in BUSY until ack or timeout.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d      = BUSY;
          grant_d      = pick;
          last_grant_d = pick[1];
          wait_cnt_d   = '0;
        end
      end
      BUSY: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        if (done) begin
          state_d = IDLE;
          grant_d = '0;
        end
        if (timeout_hit && !slave_ack && (timeout_cnt_q != '1)) begin
          timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Slave-side forwarding and master-side completion muxing.
  always_comb begin
    slave_req      = busy;
    slave_addr     = '0;
    slave_wdata    = '0;
    slave_cmd      = CMD_READ;
    master_0_ack   = done && grant_q[0];
    master_1_ack   = done && grant_q[1];
    master_0_rdata = '0;
    master_1_rdata = '0;
    if (busy) begin
      slave_addr  = sel_pl.addr;
      slave_wdata = sel_pl.wdata;
      slave_cmd   = sel_pl.cmd;
    end
    if (master_0_ack) begin
      master_0_rdata = rsp_data;
    end
    if (master_1_ack) begin
      master_1_rdata = rsp_data;
    end
  end

  assign grant       = grant_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Bench for slave_port_arbiter: directed test-plan scenarios plus randomized traffic
// checked against a transaction-level model of arbitration, completion and timeouts.
module tb_slave_port_arbiter;
  import ic_pkg::*;

  localparam int unsigned SLAVE_ID = 0;
  localparam int unsigned ADDR_BIT = 31;
  localparam int unsigned TIMEOUT  = 4;
  localparam logic [31:0] ERR_VAL  = 32'hDEAD_BEEF;
  localparam int          NEVER    = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_b = '0;
  logic [31:0] addr_b  [2];
  logic [31:0] wdata_b [2];
  logic        cmd_b   [2];
  logic [31:0] slave_rdata = '0;
  logic        slave_ack = 1'b0;

  logic [31:0] master_0_rdata, master_1_rdata;
  logic        master_0_ack, master_1_ack;
  logic        slave_req, slave_cmd;
  logic [31:0] slave_addr, slave_wdata;
  logic [1:0]  grant;
  logic [7:0]  timeout_cnt;

  int checks   = 0;
  int failures = 0;

  // Model state: last winner and expected timeout count.
  int last_m = 1;
  int tcnt_m = 0;

  slave_port_arbiter #(
    .SLAVE_ID (SLAVE_ID),
    .ADDR_BIT (ADDR_BIT),
    .TIMEOUT  (TIMEOUT),
    .ERR_DATA (ERR_VAL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .master_0_req   (req_b[0]),
    .master_0_addr  (addr_b[0]),
    .master_0_wdata (wdata_b[0]),
    .master_0_cmd   (cmd_b[0]),
    .master_0_rdata (master_0_rdata),
    .master_0_ack   (master_0_ack),
    .master_1_req   (req_b[1]),
    .master_1_addr  (addr_b[1]),
    .master_1_wdata (wdata_b[1]),
    .master_1_cmd   (cmd_b[1]),
    .master_1_rdata (master_1_rdata),
    .master_1_ack   (master_1_ack),
    .slave_req      (slave_req),
    .slave_addr     (slave_addr),
    .slave_wdata    (slave_wdata),
    .slave_cmd      (slave_cmd),
    .slave_rdata    (slave_rdata),
    .slave_ack      (slave_ack),
    .grant          (grant),
    .timeout_cnt    (timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic eligible(input int m);
    return req_b[m] && (addr_b[m][ADDR_BIT] == 1'(SLAVE_ID));
  endfunction

  // Round robin: a lone requester wins; on a tie the master that lost last time wins.
  function automatic int pick_model();
    if (eligible(0) && eligible(1)) return 1 - last_m;
    return eligible(0) ? 0 : 1;
  endfunction

  function automatic logic get_ack(input int m);
    return (m == 0) ? master_0_ack : master_1_ack;
  endfunction

  function automatic logic [31:0] get_rdata(input int m);
    return (m == 0) ? master_0_rdata : master_1_rdata;
  endfunction

  task automatic set_req(input int m, input logic [31:0] a, input logic [31:0] wd, input logic c);
    req_b[m]   = 1'b1;
    addr_b[m]  = a;
    wdata_b[m] = wd;
    cmd_b[m]   = c;
  endtask

  task automatic rand_req(input int m, input logic force_elig);
    logic [31:0] a;
    a = $urandom;
    a[ADDR_BIT] = force_elig ? 1'(SLAVE_ID) : (($urandom_range(0, 3) == 0) ? ~1'(SLAVE_ID) : 1'(SLAVE_ID));
    set_req(m, a, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sreq"},  32'(slave_req),      32'd0);
    check({tag, "_saddr"}, slave_addr,          32'd0);
    check({tag, "_swd"},   slave_wdata,         32'd0);
    check({tag, "_scmd"},  32'(slave_cmd),      32'd0);
    check({tag, "_ack0"},  32'(master_0_ack),   32'd0);
    check({tag, "_ack1"},  32'(master_1_ack),   32'd0);
    check({tag, "_rd0"},   master_0_rdata,      32'd0);
    check({tag, "_rd1"},   master_1_rdata,      32'd0);
    check({tag, "_grant"}, 32'(grant),          32'd0);
  endtask

  // Start of an IDLE cycle: drive slave side; caller may then change requests.
  task automatic begin_idle(input logic ack_noise);
    @(negedge clk);
    slave_ack   = ack_noise;
    slave_rdata = $urandom;
  endtask

  // Check the IDLE cycle: nothing forwarded, no completions, stray slave ack ignored.
  task automatic end_idle();
    #1;
    check_all_zero("idle");
    check("idle_tcnt", 32'(timeout_cnt), 32'(tcnt_m));
  endtask

  // Run one granted transaction; slave acks on BUSY cycle d (d > TIMEOUT means never).
  task automatic serve(input int d, input logic [31:0] rd);
    int          own;
    int          fin;
    logic        timed_out;
    logic [31:0] exp_rd;
    own       = pick_model();
    last_m    = own;
    timed_out = (d > int'(TIMEOUT));
    fin       = timed_out ? int'(TIMEOUT) : d;
    exp_rd    = timed_out ? ERR_VAL : rd;
    for (int c = 1; c <= fin; c++) begin
      @(negedge clk);
      slave_ack   = (c == d);
      slave_rdata = (c == d) ? rd : $urandom;
      #1;
      check("grant", 32'(grant), 32'(1 << own));
      check("sreq",  32'(slave_req), 32'd1);
      check("saddr", slave_addr, addr_b[own]);
      check("swd",   slave_wdata, wdata_b[own]);
      check("scmd",  32'(slave_cmd), 32'(cmd_b[own]));
      for (int m = 0; m < 2; m++) begin
        check("mack", 32'(get_ack(m)), 32'((c == fin) && (m == own)));
        if (m != own) begin
          check("rd_other", get_rdata(m), 32'd0);
        end else if ((c == fin) && (timed_out || cmd_b[own] == CMD_READ)) begin
          check("rd_own", get_rdata(m), exp_rd);
        end
      end
    end
    if (timed_out && tcnt_m < 255) tcnt_m++;
    req_b[own] = 1'b0;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      addr_b[m]  = '0;
      wdata_b[m] = '0;
      cmd_b[m]   = CMD_READ;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    check("reset_tcnt", 32'(timeout_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Contention: both masters hold writes, 1-cycle slave ack, expect 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      begin_idle(1'b0);
      for (int m = 0; m < 2; m++) if (!req_b[m]) begin
        rand_req(m, 1'b1);
        cmd_b[m] = CMD_WRITE;
      end
      end_idle();
      serve(1, $urandom);
    end
    begin_idle(1'b0);
    req_b = '0;
    end_idle();

    // Single read from master 0, slave acks on the third BUSY cycle.
    begin_idle(1'b0);
    set_req(0, 32'h0000_0010, 32'h0, CMD_READ);
    end_idle();
    serve(3, 32'h1234_5678);

    // Decode miss: master 1 targets the other slave, never granted.
    begin_idle(1'b0);
    set_req(1, 32'h8000_0000, 32'h55AA_55AA, CMD_WRITE);
    end_idle();
    for (int i = 0; i < 3; i++) begin
      begin_idle(1'b1);
      end_idle();
    end
    begin_idle(1'b0);
    req_b = '0;
    end_idle();

    // Timeout: slave never acks.
    begin_idle(1'b0);
    set_req(0, 32'h0000_0020, 32'h0, CMD_READ);
    end_idle();
    serve(NEVER, 32'h0);

    // Ack on the timeout cycle wins.
    begin_idle(1'b0);
    set_req(1, 32'h0000_0030, 32'h0, CMD_READ);
    end_idle();
    serve(int'(TIMEOUT), 32'hA5A5_A5A5);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      begin_idle(1'($urandom_range(0, 3) == 0));
      for (int m = 0; m < 2; m++) begin
        if (req_b[m] && !eligible(m)) req_b[m] = 1'b0;
        if (!req_b[m] && $urandom_range(0, 2) != 0) rand_req(m, 1'b0);
      end
      end_idle();
      if (eligible(0) || eligible(1)) serve($urandom_range(1, TIMEOUT + 1), $urandom);
    end
    begin_idle(1'b0);
    req_b = '0;
    end_idle();

    // Timeout counter saturation.
    for (int i = 0; i < 300; i++) begin
      begin_idle(1'b0);
      set_req(i % 2, 32'h0000_0100, $urandom, CMD_READ);
      end_idle();
      serve(NEVER, 32'h0);
    end
    begin_idle(1'b0);
    end_idle();
    check("tcnt_sat", 32'(timeout_cnt), 32'd255);

    // Reset asserted mid-BUSY clears outputs immediately, no ack for the aborted transfer.
    begin_idle(1'b0);
    set_req(1, 32'h0000_0040, 32'h1111_2222, CMD_WRITE);
    end_idle();
    @(negedge clk);
    #1;
    check("pre_rst_sreq", 32'(slave_req), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    check("rst_mid_tcnt", 32'(timeout_cnt), 32'd0);
    req_b = '0;
    @(negedge clk);
    rst    = 1'b0;
    last_m = 1;
    tcnt_m = 0;

    // After reset, master 0 wins the first tie again.
    begin_idle(1'b0);
    rand_req(0, 1'b1);
    rand_req(1, 1'b1);
    end_idle();
    serve(2, $urandom);
    begin_idle(1'b0);
    req_b = '0;
    end_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
